// File: rtl/arch_defs_pkg.sv
// SAP-2 architecture-wide constants.
package arch_defs_pkg;
    localparam int DATA_WIDTH = 8;
endpackage

// File: rtl/uart_pkg.sv
// Shared UART definitions for the SAP-2 receiver and transmitter.
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_CLK_FREQ_HZ = 20_000_000;
    localparam int UART_BAUD_RATE   = 115_200;
    localparam int UART_OVERSAMPLE  = 16;

    function automatic int baud_divisor(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction
endpackage

// File: rtl/uart_baud_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIVISOR clocks.
module uart_baud_tick_gen #(
    parameter int DIVISOR = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);
    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    generate
        if (DIVISOR < 1) begin : g_bad_divisor
            $fatal(1, "uart_baud_tick_gen: DIVISOR must be >= 1");
        end
    endgenerate

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign o_tick = w_wrap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with oversampled mid-bit sampling and sticky status flags.
module uart_receiver
    import arch_defs_pkg::*;
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = UART_CLK_FREQ_HZ,
    parameter int BAUD_RATE   = UART_BAUD_RATE,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_serial,
    input  logic                  data_read_strobe,
    input  logic                  err_clear_strobe,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_error,
    output logic                  overrun_error,
    output logic                  rx_busy
);
    localparam int DIVISOR = baud_divisor(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] SAMP_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    generate
        if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
            $fatal(1, "uart_receiver: OVERSAMPLE must be even and >= 8");
        end
    endgenerate

    uart_rx_state_t r_state, w_next;

    logic                      r_sync1, r_sync2;
    logic [SW-1:0]             r_samp;
    logic [2:0]                r_bit;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [DATA_WIDTH-1:0]     r_data;
    logic                      r_valid, r_ferr, r_oerr;

    logic w_rx, w_tick;
    logic w_samp_clr, w_samp_inc, w_bit_clr, w_shift, w_good, w_ferr;

    assign w_rx = r_sync2;

    uart_baud_tick_gen #(.DIVISOR(DIVISOR)) u_tick (
        .i_clk   (clk),
        .i_rst_n (reset),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_samp_clr = 1'b0;
        w_samp_inc = 1'b0;
        w_bit_clr  = 1'b0;
        w_shift    = 1'b0;
        w_good     = 1'b0;
        w_ferr     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_rx) begin
                    w_next     = START;
                    w_samp_clr = 1'b1;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_samp == SAMP_HALF) begin
                        if (!w_rx) begin
                            w_next     = DATA;
                            w_samp_clr = 1'b1;
                            w_bit_clr  = 1'b1;
                        end else begin
                            w_next = IDLE;
                        end
                    end else begin
                        w_samp_inc = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_samp_inc = 1'b1;
                    if (r_samp == SAMP_LAST) begin
                        w_shift = 1'b1;
                        if (r_bit == BIT_LAST) w_next = STOP;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_samp_inc = 1'b1;
                    if (r_samp == SAMP_LAST) begin
                        if (w_rx) begin
                            w_good = 1'b1;
                            w_next = IDLE;
                        end else begin
                            w_ferr = 1'b1;
                            w_next = WAIT_IDLE;
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                if (w_rx) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_samp  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
            if (w_samp_clr) begin
                r_samp <= '0;
            end else if (w_samp_inc) begin
                r_samp <= r_samp + 1'b1;
            end
            if (w_bit_clr) begin
                r_bit <= '0;
            end else if (w_shift) begin
                r_bit <= r_bit + 1'b1;
            end
            if (w_shift) r_shift <= {w_rx, r_shift[UART_DATA_BITS-1:1]};
        end
    end

    // A read in the completion cycle frees the holding register first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_oerr  <= 1'b0;
        end else begin
            if (w_good && (!r_valid || data_read_strobe)) begin
                r_data  <= DATA_WIDTH'(r_shift);
                r_valid <= 1'b1;
            end else if (data_read_strobe) begin
                r_valid <= 1'b0;
            end
            if (w_good && r_valid && !data_read_strobe) begin
                r_oerr <= 1'b1;
            end else if (err_clear_strobe) begin
                r_oerr <= 1'b0;
            end
            if (w_ferr) begin
                r_ferr <= 1'b1;
            end else if (err_clear_strobe) begin
                r_ferr <= 1'b0;
            end
        end
    end

    assign rx_data       = r_data;
    assign rx_valid      = r_valid;
    assign frame_error   = r_ferr;
    assign overrun_error = r_oerr;
    assign rx_busy       = (r_state != IDLE) && (r_state != WAIT_IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver at 1.6 MHz / 10 kbaud / x16.
module tb_uart_receiver;
    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_serial = 1'b1;
    logic       rd = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_error, overrun_error, rx_busy;

    int tests = 0;
    int fails = 0;
    int cyc;
    int last_start = 0;
    int t_rise = 0;
    int lat_k = 1520;
    logic v_q = 1'b0;

    uart_receiver #(
        .CLK_FREQ_HZ(1_600_000),
        .BAUD_RATE  (10_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_serial       (rx_serial),
        .data_read_strobe(rd),
        .err_clear_strobe(clr),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .frame_error     (frame_error),
        .overrun_error   (overrun_error),
        .rx_busy         (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rx_valid && !v_q) t_rise = cyc;
        v_q = rx_valid;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align10;
        do @(negedge clk); while (cyc % 10 != 0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopv);
        align10;
        last_start = cyc;
        rx_serial = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            wait_clks(BIT_CLKS);
        end
        rx_serial = stopv;
        wait_clks(BIT_CLKS);
    endtask

    task automatic pulse_read;
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic pulse_clear;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        wait_clks(3);
        tests++;
        if ({rx_data, rx_valid, frame_error, overrun_error, rx_busy} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 000",
                     {rx_data, rx_valid, frame_error, overrun_error, rx_busy});
        end
        reset = 1'b1;
        wait_clks(5);
        tests++;
        if (rx_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_busy: got %b want 0", rx_busy);
        end
    endtask

    task automatic test_single;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_clks(800);
                tests++;
                if (rx_busy !== 1'b1) begin
                    fails++;
                    $display("FAIL single_busy_mid: got %b want 1", rx_busy);
                end
            end
        join
        tests++;
        if (rx_data !== 8'hA5) begin
            fails++;
            $display("FAIL single_data: got %h want a5", rx_data);
        end
        tests++;
        if (rx_valid !== 1'b1 || rx_busy !== 1'b0) begin
            fails++;
            $display("FAIL single_valid_busy: got %b%b want 10", rx_valid, rx_busy);
        end
        tests++;
        if (frame_error !== 1'b0 || overrun_error !== 1'b0) begin
            fails++;
            $display("FAIL single_flags: got %b%b want 00", frame_error, overrun_error);
        end
        lat_k = t_rise - last_start;
        tests++;
        if (lat_k < 1515 || lat_k > 1535) begin
            fails++;
            $display("FAIL single_latency: got %0d want 1515..1535", lat_k);
        end
        pulse_read;
        tests++;
        if (rx_valid !== 1'b0 || rx_data !== 8'hA5) begin
            fails++;
            $display("FAIL read_clear: got %b/%h want 0/a5", rx_valid, rx_data);
        end
    endtask

    task automatic test_back_to_back;
        send_frame(8'h3C, 1'b1);
        pulse_read;
        send_frame(8'hC3, 1'b1);
        tests++;
        if (rx_data !== 8'hC3 || rx_valid !== 1'b1 || overrun_error !== 1'b0) begin
            fails++;
            $display("FAIL b2b_read: got %h/%b/%b want c3/1/0",
                     rx_data, rx_valid, overrun_error);
        end
        pulse_read;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        tests++;
        if (rx_data !== 8'h3C || rx_valid !== 1'b1 || overrun_error !== 1'b1) begin
            fails++;
            $display("FAIL b2b_overrun: got %h/%b/%b want 3c/1/1",
                     rx_data, rx_valid, overrun_error);
        end
        pulse_clear;
        tests++;
        if (overrun_error !== 1'b0) begin
            fails++;
            $display("FAIL overrun_clear: got %b want 0", overrun_error);
        end
        pulse_read;
    endtask

    task automatic test_break;
        send_frame(8'h55, 1'b0);
        tests++;
        if (frame_error !== 1'b1 || rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL break_ferr: got %b/%b want 1/0", frame_error, rx_valid);
        end
        wait_clks(2000);
        tests++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || frame_error !== 1'b1) begin
            fails++;
            $display("FAIL break_hold: got %b%b%b want 001", rx_busy, rx_valid, frame_error);
        end
        rx_serial = 1'b1;
        wait_clks(200);
        send_frame(8'h01, 1'b1);
        tests++;
        if (rx_data !== 8'h01 || rx_valid !== 1'b1 || frame_error !== 1'b1) begin
            fails++;
            $display("FAIL break_recover: got %h/%b/%b want 01/1/1",
                     rx_data, rx_valid, frame_error);
        end
        pulse_clear;
        tests++;
        if (frame_error !== 1'b0) begin
            fails++;
            $display("FAIL ferr_clear: got %b want 0", frame_error);
        end
        pulse_read;
    endtask

    task automatic test_glitch;
        align10;
        rx_serial = 1'b0;
        wait_clks(20);
        tests++;
        if (rx_busy !== 1'b1) begin
            fails++;
            $display("FAIL glitch_busy: got %b want 1", rx_busy);
        end
        wait_clks(20);
        rx_serial = 1'b1;
        wait_clks(200);
        tests++;
        if ({rx_busy, rx_valid, frame_error} !== 3'b000 || rx_data !== 8'h01) begin
            fails++;
            $display("FAIL glitch_reject: got %b%b%b/%h want 000/01",
                     rx_busy, rx_valid, frame_error, rx_data);
        end
    endtask

    task automatic test_coincident;
        send_frame(8'h11, 1'b1);
        last_start = -1;
        fork
            send_frame(8'h7E, 1'b1);
            begin
                int n;
                n = 0;
                @(negedge clk);
                while ((last_start < 0 || cyc != last_start + lat_k - 1) && n < 4000) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 4000) begin
                    tests++;
                    fails++;
                    $display("FAIL coinc_timeout: got %0d cycles want <4000", n);
                end else begin
                    rd = 1'b1;
                    @(negedge clk);
                    rd = 1'b0;
                end
            end
        join
        tests++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h7E || overrun_error !== 1'b0) begin
            fails++;
            $display("FAIL coinc_read: got %b/%h/%b want 1/7e/0",
                     rx_valid, rx_data, overrun_error);
        end
        pulse_read;
    endtask

    task automatic test_reset_midframe;
        align10;
        rx_serial = 1'b0;
        wait_clks(BIT_CLKS);
        rx_serial = 1'b1;
        wait_clks(4 * BIT_CLKS + 80);
        reset = 1'b0;
        #1;
        tests++;
        if ({rx_data, rx_valid, frame_error, overrun_error, rx_busy} !== 12'h000) begin
            fails++;
            $display("FAIL midframe_reset: got %h want 000",
                     {rx_data, rx_valid, frame_error, overrun_error, rx_busy});
        end
        wait_clks(5);
        reset = 1'b1;
        wait_clks(20);
        send_frame(8'h81, 1'b1);
        tests++;
        if (rx_data !== 8'h81 || rx_valid !== 1'b1 || frame_error !== 1'b0) begin
            fails++;
            $display("FAIL after_reset: got %h/%b/%b want 81/1/0",
                     rx_data, rx_valid, frame_error);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_break;
        test_glitch;
        test_coincident;
        test_reset_midframe;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
